// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider with period-start strobes.
// Optional build macro ODD_DUTY50_EN adds a negedge stage for exact 50% duty on odd divisors.
module clk_div_multi #(
    parameter int CHANNELS = 2,
    parameter int DIVW     = 8,
    parameter int DIV_INIT = 3
) (
    input  logic                     CLK0,
    input  logic                     reset_n,
    input  logic [CHANNELS*DIVW-1:0] div_in,
    input  logic [CHANNELS-1:0]      div_load,
    output logic [CHANNELS-1:0]      clk_out,
    output logic [CHANNELS-1:0]      stb_out,
    output logic [CHANNELS-1:0]      pending
);

    localparam logic [DIVW-1:0] DIV_RST = DIVW'(DIV_INIT);
    localparam logic [DIVW-1:0] ZERO    = {DIVW{1'b0}};
    localparam logic [DIVW-1:0] ONE     = {{(DIVW-1){1'b0}}, 1'b1};

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [DIVW-1:0] n_q, n_d, cnt_q, cnt_d, p_q, p_d;
        logic            pend_q, pend_d, clk_q, clk_d, stb_q, stb_d;
        logic            wrap_s;
        logic [DIVW-1:0] din_s;

        assign din_s = div_in[g*DIVW +: DIVW];

        // Next-state: a halted channel (N==0) takes a load at once; otherwise loads wait for the wrap.
        always_comb begin
            n_d    = n_q;
            cnt_d  = cnt_q;
            p_d    = p_q;
            pend_d = pend_q;
            clk_d  = 1'b0;
            stb_d  = 1'b0;
            wrap_s = 1'b0;
            if (n_q == ZERO) begin
                cnt_d  = ZERO;
                pend_d = 1'b0;
                if (div_load[g]) begin
                    n_d = din_s;
                end else begin
                    n_d = n_q;
                end
            end else begin
                wrap_s = (cnt_q == (n_q - ONE));
                if (wrap_s) begin
                    cnt_d  = ZERO;
                    pend_d = 1'b0;
                    if (div_load[g]) begin
                        n_d = din_s;
                    end else if (pend_q) begin
                        n_d = p_q;
                    end else begin
                        n_d = n_q;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                    if (div_load[g]) begin
                        p_d    = din_s;
                        pend_d = 1'b1;
                    end else begin
                        p_d    = p_q;
                        pend_d = pend_q;
                    end
                end
                // Phase uses the divisor of the period being entered, so its rising edge lines up with the strobe.
                clk_d = (cnt_d < {1'b0, n_d[DIVW-1:1]});
                stb_d = wrap_s && (n_d != ZERO);
            end
        end

        // Channel state register with synchronous active-low reset.
        always_ff @(posedge CLK0) begin
            if (!reset_n) begin
                n_q    <= DIV_RST;
                cnt_q  <= ZERO;
                p_q    <= ZERO;
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                stb_q  <= 1'b0;
            end else begin
                n_q    <= n_d;
                cnt_q  <= cnt_d;
                p_q    <= p_d;
                pend_q <= pend_d;
                clk_q  <= clk_d;
                stb_q  <= stb_d;
            end
        end

        assign stb_out[g] = stb_q;
        assign pending[g] = pend_q;

`ifdef ODD_DUTY50_EN
        logic neg_q;
        logic odd_s;

        // Half-cycle delayed copy of the divided clock, used to stretch odd-divisor high phases.
        always_ff @(negedge CLK0) begin
            if (!reset_n) begin
                neg_q <= 1'b0;
            end else begin
                neg_q <= clk_q;
            end
        end

        // Extension only in the cycle right after the high phase of an odd N>=3 period.
        assign odd_s      = n_q[0] && (n_q != ONE) && (cnt_q == {1'b0, n_q[DIVW-1:1]});
        assign clk_out[g] = clk_q | (neg_q & odd_s);
`else
        assign clk_out[g] = clk_q;
`endif
    end

endmodule
